// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debouncer and press/release/long-press strobe generator
module btn_conditioner #(
    parameter int                 NUM_BTN         = 7,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 LONG_CYCLES     = 25000000,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

    logic [NUM_BTN-1:0] r_sync [SYNC_STAGES];
    logic [DW-1:0]      r_deb_cnt [NUM_BTN];
    logic [HW-1:0]      r_hold_cnt [NUM_BTN];

    logic [NUM_BTN-1:0] w_norm;
    logic [NUM_BTN-1:0] w_flip;

    // Polarity-normalised synchroniser output; a 1 always means "pressed".
    assign w_norm = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK;

    // A button's level flips once it has disagreed with o_level for the full debounce window.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_flip[i] = (w_norm[i] != o_level[i]) && (r_deb_cnt[i] == DEB_LAST);
        end
    end

    // Multi-stage synchroniser; reset loads the idle pin levels so nothing looks pressed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= ACTIVE_LOW_MASK;
            end
        end else begin
            r_sync[0] <= i_btn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Debounce counters plus the level register and its edge strobes, updated together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
            o_level   <= '0;
            o_press   <= '0;
            o_release <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_norm[i] == o_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
            o_level   <= o_level ^ w_flip;
            o_press   <= w_flip & ~o_level;
            o_release <= w_flip & o_level;
        end
    end

    // Hold counters saturate at LONG_CYCLES so the long-press strobe fires once per press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_hold_cnt[i] <= '0;
            end
            o_long <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!o_level[i]) begin
                    r_hold_cnt[i] <= '0;
                end else if (r_hold_cnt[i] != HOLD_MAX) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + HW'(1);
                end
                o_long[i] <= o_level[i] && (r_hold_cnt[i] == HOLD_PRE);
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench with a windowed behavioural model for btn_conditioner
module tb_btn_conditioner;

    localparam int             NB   = 7;
    localparam int             SS   = 2;
    localparam int             DB   = 4;
    localparam int             LC   = 10;
    localparam logic [NB-1:0]  MASK = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = MASK;
    logic [NB-1:0] o_level, o_press, o_release, o_long;

    int errors = 0;
    int checks = 0;

    btn_conditioner #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LC), .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // Model: pin history per edge; level flips when the last DB normalised samples
    // (seen SS edges late) all disagree with it; long fires LC edges after press.
    logic [NB-1:0] hist [0:255];
    int            n = 0;
    int            valid_since = 0;
    int            t_press [NB];
    bit            model_ok = 0;
    logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;

    always @(posedge clk) begin
        logic [NB-1:0] lv_old;
        logic          tog;
        logic          nm;
        if (rst) begin
            hist[n % 256] = MASK;
            valid_since = n + 1;
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int b = 0; b < NB; b++) t_press[b] = -1000;
            model_ok = 1;
        end else begin
            hist[n % 256] = btn;
            lv_old = m_level;
            for (int b = 0; b < NB; b++) begin
                tog = (n - valid_since + 1 >= DB);
                for (int k = 0; k < DB; k++) begin
                    nm = hist[(n - k - SS + 256) % 256][b] ^ MASK[b];
                    if (nm == lv_old[b]) tog = 1'b0;
                end
                m_press[b] = tog && !lv_old[b];
                m_rel[b]   = tog && lv_old[b];
                m_long[b]  = lv_old[b] && (n - t_press[b] == LC);
                if (m_press[b]) t_press[b] = n;
                m_level[b] = lv_old[b] ^ tog;
            end
        end
        n++;
    end

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("level", o_level, m_level);
            chk("press", o_press, m_press);
            chk("release", o_release, m_rel);
            chk("long", o_long, m_long);
        end
    end

    int n_press [NB];
    int n_rel   [NB];
    int n_long  [NB];
    initial for (int b = 0; b < NB; b++) begin n_press[b] = 0; n_rel[b] = 0; n_long[b] = 0; end

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (o_press[b] === 1'b1) n_press[b]++;
            if (o_release[b] === 1'b1) n_rel[b]++;
            if (o_long[b] === 1'b1) n_long[b]++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Counts edges from the next posedge until the chosen strobe is seen; -1 on timeout.
    task automatic wait_strobe(input int sel, input int b, input int maxc, output int edges);
        bit found = 0;
        edges = 0;
        while (!found && edges < maxc) begin
            @(posedge clk);
            #1;
            edges++;
            case (sel)
                0:       found = (o_press[b] === 1'b1);
                1:       found = (o_release[b] === 1'b1);
                default: found = (o_long[b] === 1'b1);
            endcase
        end
        if (!found) edges = -1;
    endtask

    int e;

    initial begin
        // 1. reset and idle
        rst = 1'b1; btn = MASK;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        chk("t1_idle_level", o_level, '0);
        chk("t1_idle_strobes", o_press | o_release | o_long, '0);

        // 2. clean press / release on bit 3
        btn[3] = 1'b1;
        wait_strobe(0, 3, 40, e);
        chk_int("t2_press_latency", e, 6);
        cyc(3);
        btn[3] = 1'b0;
        wait_strobe(1, 3, 40, e);
        chk_int("t2_release_latency", e, 6);
        cyc(5);
        chk_int("t2_press_count", n_press[3], 1);
        chk_int("t2_release_count", n_rel[3], 1);

        // 3. bounce rejection on bit 2
        btn[2] = 1'b1; cyc(1);
        btn[2] = 1'b0; cyc(2);
        btn[2] = 1'b1; cyc(3);
        btn[2] = 1'b0; cyc(1);
        chk_int("t3_no_press_in_bounce", n_press[2], 0);
        btn[2] = 1'b1;
        wait_strobe(0, 2, 40, e);
        chk_int("t3_press_latency", e, 6);
        cyc(2);
        btn[2] = 1'b0;
        wait_strobe(1, 2, 40, e);
        chk_int("t3_release_latency", e, 6);
        cyc(2);
        chk_int("t3_press_count", n_press[2], 1);

        // 4. active-low button 0 held for a long press
        btn[0] = 1'b0;
        wait_strobe(0, 0, 40, e);
        chk_int("t4_press_latency", e, 6);
        wait_strobe(2, 0, 40, e);
        chk_int("t4_long_latency", e, 10);
        cyc(15);
        chk_int("t4_long_once", n_long[0], 1);
        btn[0] = 1'b1;
        wait_strobe(1, 0, 40, e);
        chk_int("t4_release_latency", e, 6);
        cyc(2);

        // 5. long then short press on bit 5
        btn[5] = 1'b1;
        wait_strobe(0, 5, 40, e);
        chk_int("t5_press_latency", e, 6);
        wait_strobe(2, 5, 40, e);
        chk_int("t5_long_latency", e, 10);
        cyc(4);
        btn[5] = 1'b0;
        wait_strobe(1, 5, 40, e);
        chk_int("t5_release_latency", e, 6);
        cyc(2);
        btn[5] = 1'b1;
        wait_strobe(0, 5, 40, e);
        chk_int("t5_short_press_latency", e, 6);
        cyc(2);
        btn[5] = 1'b0;
        wait_strobe(1, 5, 40, e);
        chk_int("t5_short_release_latency", e, 6);
        cyc(12);
        chk_int("t5_long_count", n_long[5], 1);
        chk_int("t5_release_count", n_rel[5], 2);

        // 6. reset mid-debounce on bit 1
        btn[1] = 1'b1;
        cyc(4);
        rst = 1'b1;
        cyc(3);
        chk("t6_reset_level", o_level, '0);
        chk("t6_reset_strobes", o_press | o_release | o_long, '0);
        rst = 1'b0;
        wait_strobe(0, 1, 40, e);
        chk_int("t6_press_after_reset", e, 6);
        cyc(2);
        btn[1] = 1'b0;
        wait_strobe(1, 1, 40, e);
        chk_int("t6_release_latency", e, 6);
        cyc(3);
        chk_int("t6_press_count", n_press[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side counterpart to the LED output path: conditions the raw board push-buttons into clean, synchronous control signals for the rest of the design.
- Per button, the block:
  - synchronises the raw input,
  - normalises its polarity,
  - debounces it,
  - emits single-cycle press, release and long-press strobes.
- Sits directly behind the top-level button pins. All downstream logic (mode select, palette/zoom control for the thermal pipeline) consumes its outputs instead of raw pins.

Parameters:
- NUM_BTN, 7, number of button inputs handled.
- SYNC_STAGES, 2, flip-flop synchroniser depth per button; minimum 2.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a level change (10 ms at 25 MHz); minimum 2.
- LONG_CYCLES, 25000000, cycles of debounced press before the long-press strobe (1 s at 25 MHz); minimum 1.
- ACTIVE_LOW_MASK, 7'b0000001, bit i = 1 means button i reads 0 when pressed (board power button on bit 0).

Ports:
- i_clk, input, 1, system clock; all logic on its rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_btn, input, NUM_BTN, raw asynchronous button pins.
- o_level, output, NUM_BTN, debounced level; 1 = pressed, after polarity normalisation.
- o_press, output, NUM_BTN, one-cycle strobe on an accepted press.
- o_release, output, NUM_BTN, one-cycle strobe on an accepted release.
- o_long, output, NUM_BTN, one-cycle strobe after LONG_CYCLES of continuous press.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high. No other clocks or resets.
- All buttons are fully independent; there is no cross-button interaction.
- Normalisation: norm[i] = synchronised i_btn[i] XOR ACTIVE_LOW_MASK[i].
- Reset, taking effect on the first i_clk edge with i_rst = 1:
  - Synchroniser stages load ACTIVE_LOW_MASK, so norm = 0.
  - Debounce and hold counters are cleared.
  - o_level, o_press, o_release and o_long are all 0.
  - Reset asserted mid-debounce or mid-hold discards all progress.
  - No strobe fires on the first edges after reset release.
- Debounce counter (one per button):
  - Width is $clog2(DEBOUNCE_CYCLES).
  - If norm[i] == o_level[i]: counter is cleared.
  - If they differ and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If they differ and counter == DEBOUNCE_CYCLES-1: o_level[i] toggles and the counter clears.
  - Any single matching sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: o_level changes on rising edge number SYNC_STAGES + DEBOUNCE_CYCLES, counting the first edge that samples the new pin value as edge 1.
- Strobes:
  - o_press[i] and o_release[i] are registered together with o_level[i].
  - o_press is high for exactly the one cycle in which o_level first reads 1.
  - o_release is high for exactly the one cycle in which o_level first reads 0.
  - o_press and o_release are never high simultaneously.
- Hold counter (one per button):
  - Width is $clog2(LONG_CYCLES+1).
  - Cleared while o_level[i] = 0.
  - Increments on every edge while o_level[i] = 1, saturating at LONG_CYCLES.
  - o_long[i] is high for one cycle on the edge where the counter transitions to LONG_CYCLES, i.e. LONG_CYCLES edges after the o_press edge.
  - At most one o_long per press; no auto-repeat.
  - Release before reaching LONG_CYCLES produces no o_long.
  - Release after o_long produces a normal o_release.
- Wrap-around: neither counter can wrap; both are bounded by their compare and saturate logic.

Test Plan:
Benches run with NUM_BTN=7, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW_MASK=7'b0000001.
1. Reset and idle:
   - Stimulus: i_btn=7'b0000001 held; i_rst=1 for 3 cycles, then 0 for 20 cycles.
   - Response: all outputs 0 throughout.
2. Clean press on bit 3:
   - Stimulus: drive i_btn[3]=1 and hold.
   - Response: o_level[3] rises on edge 6 after the first sampling edge; o_press[3] is high for exactly that cycle.
   - Then release and hold → o_level[3] falls 6 edges later, with a single o_release[3].
3. Bounce rejection:
   - Stimulus: i_btn[2] toggles 1,0,1,0 on successive cycles (each value held ≤3 cycles), then 1 held.
   - Response: one o_press[2], exactly 6 edges after the final 1 is first sampled; no strobes during the bounce.
4. Active-low button:
   - Stimulus: drive i_btn[0]=0 for 20 cycles.
   - Response: o_level[0]=1, a single o_press[0], and o_long[0] 10 edges after the o_press edge.
5. Long press vs short press on bit 5:
   - Hold o_level[5]=1 for 15 cycles → one o_long at cycle 10 after o_press, no repeat, then o_release after the pin is released.
   - Hold o_level[5]=1 for only 8 cycles → no o_long.
6. Reset mid-operation:
   - Stimulus: assert i_rst after 2 of 4 debounce samples on bit 1, with the pin still pressed.
   - Response: outputs are 0 during reset.
   - After release of reset, o_press[1] occurs a full 6 edges later; the partial count is not reused.
